issue_queue: RTL

//  Parametrised fetch/issue buffer between the multi-instruction fetch stage and the LANES decode lanes.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/issue_queue_dep_check.sv | 25 ++
 rtl/issue_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// MIPS opcode/funct encodings and per-instruction register-usage decode
// shared by the issue queue hazard logic.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Destination register; 0 means the instruction writes nothing.
  function automatic logic [4:0] instrDest(input logic [31:0] instr);
    logic [4:0] d;
    d = '0;
    case (instr[31:26])
      OP_RTYPE: if (instr[5:0] != FN_JR) d = instr[15:11];
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: d = instr[20:16];
      OP_JAL: d = 5'd31;
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic instrReadsRs(input logic [31:0] instr);
    return !(instr[31:26] inside {OP_J, OP_JAL, OP_LUI});
  endfunction

  function automatic logic instrReadsRt(input logic [31:0] instr);
    return instr[31:26] inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction

  function automatic logic instrIsCtrl(input logic [31:0] instr);
    return (instr[31:26] inside {OP_BEQ, OP_BNE, OP_J, OP_JAL}) ||
           (instr[31:26] == OP_RTYPE && instr[5:0] == FN_JR);
  endfunction

endpackage

// File: rtl/issue_queue_dep_check.sv
// Pairwise hazard check between an older instruction (instrJ) and a younger
// one (instrK) offered in the same issue bundle.
module dep_check
  import mips_pkg::*;
(
  input  logic [31:0] instrJ,
  input  logic [31:0] instrK,
  output logic        conflict
);

  logic [4:0] destJ;
  logic       raw;
  logic       waw;

  // RAW / WAW against the older destination; an older control op ends the bundle.
  always_comb begin
    destJ    = instrDest(instrJ);
    raw      = (destJ != '0) &&
               ((instrReadsRs(instrK) && instrK[25:21] == destJ) ||
                (instrReadsRt(instrK) && instrK[20:16] == destJ));
    waw      = (destJ != '0) && (destJ == instrDest(instrK));
    conflict = raw || waw || instrIsCtrl(instrJ);
  end

endmodule

// File: rtl/issue_queue.sv
// Fetch/issue buffer: fetch pushes LANES instructions per cycle, issue
// dequeues an in-order bundle of 0..LANES, split at intra-bundle hazards.
module issue_queue
  import mips_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid,
  input  logic [LANES*32-1:0]          fetch_instr,
  input  logic [31:0]                  fetch_pc,
  output logic                         fetch_ready,
  input  logic                         issue_stall,
  input  logic                         flush,
  output logic [LANES-1:0]             issue_valid,
  output logic [LANES*32-1:0]          issue_instr,
  output logic [LANES*32-1:0]          issue_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [OW-1:0] occ;

  logic [31:0]                     laneInstr [LANES];
  logic [LANES-1:0][LANES-1:0]     conf;
  logic                            push;
  logic                            pop;
  logic [OW-1:0]                   popCnt;
  logic                            prevOk;

  // Present the LANES head entries; pointer arithmetic wraps in PW bits.
  always_comb begin
    issue_instr = '0;
    issue_pc    = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      laneInstr[k]         = instrMem[head + PW'(k)];
      issue_instr[32*k+:32] = laneInstr[k];
      issue_pc[32*k+:32]    = pcMem[head + PW'(k)];
    end
  end

  // One checker per (older j, younger k) pair; unused slots tie to zero.
  for (genvar k = 0; k < LANES; k++) begin : gLaneK
    for (genvar j = 0; j < LANES; j++) begin : gLaneJ
      if (j < k) begin : gPair
        dep_check uDep (
          .instrJ   (laneInstr[j]),
          .instrK   (laneInstr[k]),
          .conflict (conf[k][j])
        );
      end else begin : gNone
        assign conf[k][j] = 1'b0;
      end
    end
  end

  // Thermometer issue mask, pop count, and handshake qualifiers.
  always_comb begin
    issue_valid = '0;
    popCnt      = '0;
    prevOk      = 1'b1;
    for (int unsigned k = 0; k < LANES; k++) begin
      issue_valid[k] = prevOk && (occ > OW'(k)) && !(|conf[k]);
      prevOk         = issue_valid[k];
      popCnt         = popCnt + OW'(issue_valid[k]);
    end
    fetch_ready = (occ <= OW'(DEPTH - LANES));
    push        = fetch_valid && fetch_ready && !flush;
    pop         = !issue_stall && !flush;
  end

  assign occupancy = occ;

  // Pointer and occupancy update; flush clears everything and wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= tail + PW'(LANES);
      if (pop)  head <= head + PW'(popCnt);
      occ <= occ + (push ? OW'(LANES) : '0) - (pop ? popCnt : '0);
    end
  end

  // Entry storage; validity is tracked by occupancy so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        instrMem[tail + PW'(k)] <= fetch_instr[32*k+:32];
        pcMem[tail + PW'(k)]    <= fetch_pc + 32'(4*k);
      end
    end
  end

endmodule
